// File: rtl/shift_cmd_seq.sv
// rtl/shift_cmd_seq.sv - command FIFO and sequencer driving an 8-bit shift register
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command FIFO can accept (low while full or in reset)
//   cmd_op     opcode to issue downstream
//   cmd_data   load value, or serial-in bit source for op 101
//   cmd_count  number of issue cycles; 0 means 16 (op 001 always issues once)
//   op         opcode to the downstream shift register
//   data_out   data_in to the downstream shift register
//   busy       a command is queued or executing
//   done       one-cycle pulse on the last issue cycle of each command
module shift_cmd_seq #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [3:0] cmd_count,
    output logic [2:0] op,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SIN  = 3'b101;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t state, state_next;

    // FIFO entry layout: {op[14:12], data[11:4], count[3:0]}
    logic [14:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [2:0]    head_op;
    logic [7:0]    head_data;
    logic [3:0]    head_cnt;

    logic [2:0]    cur_op;
    logic [7:0]    data_reg;
    logic [4:0]    remaining;

    assign full      = (occ == (AW+1)'(DEPTH));
    assign empty     = (occ == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;

    assign head_op   = mem[rd_ptr][14:12];
    assign head_data = mem[rd_ptr][11:4];
    assign head_cnt  = mem[rd_ptr][3:0];

    assign op       = (state == EXEC) ? cur_op   : 3'b000;
    assign data_out = (state == EXEC) ? data_reg : 8'h00;
    assign done     = (state == EXEC) && (remaining == 5'd1);
    assign busy     = (state == EXEC) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The next command is popped on the final issue cycle so consecutive
    // commands run back-to-back with no hold cycle between them.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (remaining == 5'd1) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_data, cmd_count};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            cur_op    <= 3'b000;
            data_reg  <= 8'h00;
            remaining <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase

            if (pop) begin
                cur_op   <= head_op;
                data_reg <= head_data;
                if (head_op == OP_LOAD) begin
                    remaining <= 5'd1;
                end else if (head_cnt == 4'd0) begin
                    remaining <= 5'd16;
                end else begin
                    remaining <= {1'b0, head_cnt};
                end
            end else if (state == EXEC) begin
                remaining <= remaining - 5'd1;
                // Serial-in presents the next source bit on data_out[0] each cycle.
                if (cur_op == OP_SIN) begin
                    data_reg <= {1'b0, data_reg[7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb/tb_shift_cmd_seq.sv - self-checking bench for shift_cmd_seq
module tb_shift_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_count = 4'd0;
    logic [2:0] op;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_cmd_seq #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .op        (op),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Downstream 8-bit shift register driven by op/data_out.
    logic [7:0] ds = 8'h00;
    always @(posedge clk) begin
        case (op)
            3'd1: ds <= data_out;
            3'd2: ds <= {1'b0, ds[7:1]};
            3'd3: ds <= {ds[6:0], 1'b0};
            3'd4: ds <= {ds[7], ds[7:1]};
            3'd5: ds <= {data_out[0], ds[7:1]};
            3'd6: ds <= {ds[0], ds[7:1]};
            3'd7: ds <= {ds[6:0], ds[7]};
            default: ds <= ds;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] cnt;
        logic       e_ready;
        logic [2:0] e_op;
        logic [7:0] e_dout;
        logic       e_busy;
        logic       e_done;
        logic       ds_chk;
        logic [7:0] e_ds;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [2:0] o, logic [7:0] d, logic [3:0] c,
                                logic er, logic [2:0] eo, logic [7:0] ed, logic eb, logic edn,
                                logic dc, logic [7:0] eds);
        vec_t t;
        t.rst = r; t.valid = v; t.op = o; t.data = d; t.cnt = c;
        t.e_ready = er; t.e_op = eo; t.e_dout = ed; t.e_busy = eb; t.e_done = edn;
        t.ds_chk = dc; t.e_ds = eds;
        return t;
    endfunction

    vec_t tbl[$];

    logic [2:0] bops [4];
    logic [3:0] bcnt [4];
    logic [2:0] trace[$];
    logic [7:0] sin_seq [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n110;
        int ndone;
        int idx;
        bit stall;
        bit started;
        bit leak;
        int e;

        sin_seq = '{8'hB2, 8'h59, 8'h2C, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01};

        // Load then shift
        tbl.push_back(mk(1, 1, 3'd1, 8'hA5, 4'd5,   0, 3'd0, 8'h00, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 3'd1, 8'hA5, 4'd5,   1, 3'd0, 8'h00, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 3'd2, 8'h00, 4'd3,   1, 3'd0, 8'h00, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd1, 8'hA5, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd2, 8'h00, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd2, 8'h00, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd2, 8'h00, 1, 1, 0, 8'h00));
        // Hold for 4
        tbl.push_back(mk(0, 1, 3'd0, 8'h3C, 4'd4,   1, 3'd0, 8'h00, 0, 0, 1, 8'h14));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd0, 8'h00, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd0, 8'h3C, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd0, 8'h3C, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd0, 8'h3C, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd0, 8'h3C, 1, 1, 0, 8'h00));
        // Clear then serial-in 0xB2
        tbl.push_back(mk(0, 1, 3'd1, 8'h00, 4'd1,   1, 3'd0, 8'h00, 0, 0, 1, 8'h14));
        tbl.push_back(mk(0, 1, 3'd5, 8'hB2, 4'd8,   1, 3'd0, 8'h00, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd1, 8'h00, 1, 1, 0, 8'h00));
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0, 1, 3'd5, sin_seq[k], 1, (k == 7), 0, 8'h00));
        end
        tbl.push_back(mk(0, 0, 3'd0, 8'h00, 4'd0,   1, 3'd0, 8'h00, 0, 0, 1, 8'hB2));

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            cmd_valid = tbl[i].valid;
            cmd_op    = tbl[i].op;
            cmd_data  = tbl[i].data;
            cmd_count = tbl[i].cnt;
            #1;
            chk($sformatf("v%0d cmd_ready", i), cmd_ready, tbl[i].e_ready);
            chk($sformatf("v%0d op", i),        op,        tbl[i].e_op);
            chk($sformatf("v%0d data_out", i),  data_out,  tbl[i].e_dout);
            chk($sformatf("v%0d busy", i),      busy,      tbl[i].e_busy);
            chk($sformatf("v%0d done", i),      done,      tbl[i].e_done);
            if (tbl[i].ds_chk) begin
                chk($sformatf("v%0d downstream", i), ds, tbl[i].e_ds);
            end
        end

        // Count zero: rotate right for 16 cycles returns the register to 0xB2
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_data = 8'h5A; cmd_count = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n110 = 0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (op == 3'd6) n110++;
            if (done) ndone++;
            @(negedge clk);
        end
        chk("cnt0 op110 cycles", n110, 16);
        chk("cnt0 done pulses", ndone, 1);
        chk("cnt0 downstream", ds, 8'hB2);
        chk("cnt0 busy after", busy, 0);

        // Backpressure: one 16-cycle command executing, three more offered
        bops = '{3'd6, 3'd3, 3'd2, 3'd7};
        bcnt = '{4'd0, 4'd2, 4'd2, 4'd1};
        idx = 0;
        stall = 1'b0;
        started = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (idx < 4) begin
                cmd_valid = 1'b1; cmd_op = bops[idx]; cmd_count = bcnt[idx]; cmd_data = 8'h11;
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            if (idx == 3 && !cmd_ready) stall = 1'b1;
            if (op != 3'd0) started = 1'b1;
            if (started && busy) trace.push_back(op);
            if (cmd_valid && cmd_ready) idx++;
        end
        cmd_valid = 1'b0;
        chk("bp third stalled", stall, 1);
        chk("bp all accepted", idx, 4);
        chk("bp trace length", trace.size(), 21);
        for (int k = 0; k < 21; k++) begin
            e = (k < 16) ? 6 : (k < 18) ? 3 : (k < 20) ? 2 : 7;
            if (k < trace.size()) chk($sformatf("bp trace[%0d]", k), trace[k], e);
        end

        // Reset on the third issue cycle of a command with one queued
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 8'h00; cmd_count = 4'd8;
        @(negedge clk);
        cmd_op = 3'd1; cmd_data = 8'h77; cmd_count = 4'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("rst first issue op", op, 3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst third issue op", op, 3);
        chk("rst cmd_ready low", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst after op", op, 0);
        chk("rst after busy", busy, 0);
        chk("rst after done", done, 0);
        chk("rst after ready", cmd_ready, 1);
        leak = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (op != 3'd0 || busy) leak = 1'b1;
        end
        chk("rst queued never issued", leak, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
